// File: rtl/audio_avg_bridge.sv
// Stereo codec bridge: paces one pair at a time, optional N-tap moving average per channel.
// Latency: pair captured on the read edge, outputs registered one cycle later, write offered from then on.
// Backpressure: holds in WRITE with outputs stable and read deasserted until write_ready.
`timescale 1ns/1ps
module audio_avg_bridge #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic              write_ready,
    input  logic              filter_en,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = DATA_W + LOG2_N;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;

    logic [1:0]           state;
    logic [DATA_W-1:0]    in_l;
    logic [DATA_W-1:0]    in_r;
    logic                 in_filt;
    logic [LOG2_N-1:0]    ptr;
    logic [DATA_W-1:0]    hist_l [N];
    logic [DATA_W-1:0]    hist_r [N];
    logic signed [SW-1:0] sum_l;
    logic signed [SW-1:0] sum_r;
    logic signed [SW-1:0] sum_l_nxt;
    logic signed [SW-1:0] sum_r_nxt;

    function automatic logic signed [SW-1:0] sext(input logic [DATA_W-1:0] x);
        return {{LOG2_N{x[DATA_W-1]}}, x};
    endfunction

    assign read  = (state == S_IDLE) && read_ready;
    assign write = (state == S_WRITE) && write_ready;
    assign busy  = (state != S_IDLE);

    // Oldest sample is read asynchronously at ptr and swapped out for the new one.
    always_comb begin
        sum_l_nxt = sum_l - sext(hist_l[ptr]) + sext(in_l);
        sum_r_nxt = sum_r - sext(hist_r[ptr]) + sext(in_r);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (read_ready) state <= S_COMPUTE;
                S_COMPUTE: state <= S_WRITE;
                S_WRITE:   if (write_ready) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            in_l            <= '0;
            in_r            <= '0;
            in_filt         <= 1'b0;
            ptr             <= '0;
            sum_l           <= '0;
            sum_r           <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            for (int i = 0; i < N; i++) begin
                hist_l[i] <= '0;
                hist_r[i] <= '0;
            end
        end else begin
            if (read) begin
                in_l    <= readdata_left;
                in_r    <= readdata_right;
                in_filt <= filter_en;
            end
            if (state == S_COMPUTE) begin
                sum_l       <= sum_l_nxt;
                sum_r       <= sum_r_nxt;
                hist_l[ptr] <= in_l;
                hist_r[ptr] <= in_r;
                ptr         <= ptr + 1'b1;
                // Upper DATA_W bits of the sum are the arithmetic shift by LOG2_N (floor).
                if (in_filt) begin
                    writedata_left  <= sum_l_nxt[LOG2_N +: DATA_W];
                    writedata_right <= sum_r_nxt[LOG2_N +: DATA_W];
                end else begin
                    writedata_left  <= in_l;
                    writedata_right <= in_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_avg_bridge.sv
// Randomized bench for audio_avg_bridge with a queue-based moving-average reference model.
`timescale 1ns/1ps
module tb_audio_avg_bridge;
    localparam int DW  = 24;
    localparam int L2N = 2;
    localparam int NT  = 1 << L2N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic          write_ready = 1'b0;
    logic          filter_en = 1'b0;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int ref_l[$];
    int ref_r[$];

    audio_avg_bridge #(.DATA_W(DW), .LOG2_N(L2N)) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write_ready     (write_ready),
        .filter_en       (filter_en),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        int q;
        q = s / NT;
        if ((s % NT) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        ref_l = {};
        ref_r = {};
        for (int i = 0; i < NT; i++) begin
            ref_l.push_back(0);
            ref_r.push_back(0);
        end
    endtask

    // Window of the last NT samples; output is their floor average or the raw sample.
    task automatic model_push(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic f,
                              output logic [DW-1:0] el, output logic [DW-1:0] er);
        int sl;
        int sr;
        int ql;
        int qr;
        void'(ref_l.pop_front());
        void'(ref_r.pop_front());
        ref_l.push_back(int'($signed(l)));
        ref_r.push_back(int'($signed(r)));
        sl = 0;
        sr = 0;
        foreach (ref_l[i]) sl += ref_l[i];
        foreach (ref_r[i]) sr += ref_r[i];
        ql = floor_div(sl);
        qr = floor_div(sr);
        el = f ? ql[DW-1:0] : l;
        er = f ? qr[DW-1:0] : r;
    endtask

    // Called at a negedge: asserts reset mid low-phase and checks outputs before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        read_ready = 1'b0;
        write_ready = 1'b0;
        #1;
        check("rst_read", 32'(read), 0);
        check("rst_write", 32'(write), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wdl", 32'(writedata_left), 0);
        check("rst_wdr", 32'(writedata_right), 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One full pair: read handshake, compute, bp cycles of back-pressure, write handshake.
    task automatic xfer(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic f, input int bp);
        logic [DW-1:0] el;
        logic [DW-1:0] er;
        @(negedge clk);
        readdata_left  = l;
        readdata_right = r;
        filter_en      = f;
        read_ready     = 1'b1;
        write_ready    = (bp == 0);
        #1;
        check("read_pulse", 32'(read), 1);
        check("idle_busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        read_ready     = (bp > 0);
        readdata_left  = DW'($urandom);
        readdata_right = DW'($urandom);
        filter_en      = ~f;
        #1;
        check("compute_read", 32'(read), 0);
        check("compute_write", 32'(write), 0);
        check("compute_busy", 32'(busy), 1);
        model_push(l, r, f, el, er);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < bp; i++) begin
            check("bp_write", 32'(write), 0);
            check("bp_read", 32'(read), 0);
            check("bp_busy", 32'(busy), 1);
            check("bp_hold_l", 32'(writedata_left), 32'(el));
            check("bp_hold_r", 32'(writedata_right), 32'(er));
            @(posedge clk);
            @(negedge clk);
        end
        write_ready = 1'b1;
        #1;
        check("write_pulse", 32'(write), 1);
        check("write_no_read", 32'(read), 0);
        check("out_l", 32'(writedata_left), 32'(el));
        check("out_r", 32'(writedata_right), 32'(er));
        @(posedge clk);
        @(negedge clk);
        check("post_write", 32'(write), 0);
        check("post_busy", 32'(busy), 0);
        if (bp > 0) check("post_bp_read", 32'(read), 1);
        read_ready  = 1'b0;
        write_ready = 1'b0;
    endtask

    initial begin
        model_clear();
        #7;
        check("init_read", 32'(read), 0);
        check("init_write", 32'(write), 0);
        check("init_busy", 32'(busy), 0);
        check("init_wdl", 32'(writedata_left), 0);
        check("init_wdr", 32'(writedata_right), 0);
        @(negedge clk);
        reset = 1'b0;

        // Bypass of fixed values
        xfer(24'h123456, 24'hFEDCBA, 1'b0, 0);

        // Filter step response from cleared history (also resets a non-zero DUT)
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) xfer(24'd400, 24'd400, 1'b1, 0);
        xfer(24'd0, 24'd0, 1'b1, 0);

        // Signed rounding toward minus infinity
        @(negedge clk);
        do_reset();
        xfer(24'hFFFFFC, 24'hFFFFFC, 1'b1, 0);
        @(negedge clk);
        do_reset();
        xfer(24'hFFFFFF, 24'hFFFFFF, 1'b1, 0);

        // Long back-pressure with the codec still offering data
        xfer(DW'($urandom), DW'($urandom), 1'b1, 10);

        // Randomized traffic with mode toggles and occasional resets
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                do_reset();
            end
            xfer(DW'($urandom), DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset while a pair is parked in WRITE
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) xfer(24'd400, 24'd400, 1'b1, 0);
        @(negedge clk);
        readdata_left  = 24'd400;
        readdata_right = 24'd400;
        filter_en      = 1'b1;
        read_ready     = 1'b1;
        write_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("parked_busy", 32'(busy), 1);
        check("parked_write", 32'(write), 0);
        do_reset();
        xfer(24'd400, 24'd400, 1'b1, 0);
        xfer(24'd400, 24'd400, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
